// File: rtl/uid_auth_ctrl.sv
// uid_auth_ctrl: constant-time password check that drives the register-file user ID.
// Ports: CLK, RST (sync, active-high); LOGIN_REQ/ID/PW, LOGOUT, ACTIVITY in;
//        U_ID {priv,id}, BUSY, GRANT, DENY, LOCKED, FAIL_CNT out (all registered).
module uid_auth_ctrl #(
  parameter logic [15:0] PRIV_PW  = 16'hA5C3,
  parameter int          TIMEOUT  = 1024,
  parameter int          MAX_FAIL = 3,
  parameter int          LOCKOUT  = 4096
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        LOGIN_REQ,
  input  logic [10:0] LOGIN_ID,
  input  logic [15:0] LOGIN_PW,
  input  logic        LOGOUT,
  input  logic        ACTIVITY,
  output logic [11:0] U_ID,
  output logic        BUSY,
  output logic        GRANT,
  output logic        DENY,
  output logic        LOCKED,
  output logic [1:0]  FAIL_CNT
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_PRIV,
    S_LOCK
  } state_t;

  // One timer serves both PRIV idle and LOCKOUT; they never overlap.
  localparam int TMAX = (TIMEOUT > LOCKOUT) ? TIMEOUT : LOCKOUT;
  localparam int TW   = $clog2(TMAX);
  localparam logic [TW-1:0] T_TO = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] T_LK = TW'(LOCKOUT - 1);
  localparam logic [1:0]    MAXF = 2'(MAX_FAIL);

  state_t        state_q, state_d;
  logic [10:0]   id_q, id_d;
  logic [15:0]   pw_q, pw_d;
  logic          mis_q, mis_d;
  logic [1:0]    nib_q, nib_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [11:0]   uid_q, uid_d;
  logic          busy_q, busy_d;
  logic          grant_q, grant_d;
  logic          deny_q, deny_d;
  logic          lock_q, lock_d;
  logic [1:0]    fail_q, fail_d;

  logic          mis_now;
  logic [1:0]    fail_inc;
  logic [3:0]    nib_base;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      id_q    <= '0;
      pw_q    <= '0;
      mis_q   <= 1'b0;
      nib_q   <= '0;
      tmr_q   <= '0;
      uid_q   <= '0;
      busy_q  <= 1'b0;
      grant_q <= 1'b0;
      deny_q  <= 1'b0;
      lock_q  <= 1'b0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      pw_q    <= pw_d;
      mis_q   <= mis_d;
      nib_q   <= nib_d;
      tmr_q   <= tmr_d;
      uid_q   <= uid_d;
      busy_q  <= busy_d;
      grant_q <= grant_d;
      deny_q  <= deny_d;
      lock_q  <= lock_d;
      fail_q  <= fail_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    pw_d     = pw_q;
    mis_d    = mis_q;
    nib_d    = nib_q;
    tmr_d    = tmr_q;
    uid_d    = uid_q;
    busy_d   = busy_q;
    grant_d  = 1'b0;
    deny_d   = 1'b0;
    lock_d   = lock_q;
    fail_d   = fail_q;
    nib_base = {nib_q, 2'b00};
    // All four nibbles are always compared: no early exit on mismatch.
    mis_now  = mis_q |
               (pw_q[nib_base +: 4] != PRIV_PW[nib_base +: 4]);
    fail_inc = (fail_q >= MAXF) ? fail_q : fail_q + 2'd1;

    unique case (state_q)
      S_IDLE: begin
        if (LOGIN_REQ) begin
          id_d    = LOGIN_ID;
          pw_d    = LOGIN_PW;
          mis_d   = 1'b0;
          nib_d   = '0;
          busy_d  = 1'b1;
          state_d = S_CHECK;
        end else if (LOGOUT) begin
          uid_d = '0;
        end
      end
      S_CHECK: begin
        mis_d = mis_now;
        nib_d = nib_q + 2'd1;
        if (nib_q == 2'd3) begin
          busy_d = 1'b0;
          if (!mis_now) begin
            uid_d   = {1'b1, id_q};
            grant_d = 1'b1;
            fail_d  = '0;
            tmr_d   = '0;
            state_d = S_PRIV;
          end else begin
            deny_d = 1'b1;
            fail_d = fail_inc;
            if (fail_inc == MAXF) begin
              lock_d  = 1'b1;
              uid_d   = '0;
              tmr_d   = '0;
              state_d = S_LOCK;
            end else begin
              uid_d   = {1'b0, id_q};
              state_d = S_IDLE;
            end
          end
        end
      end
      S_PRIV: begin
        if (LOGOUT) begin
          uid_d   = '0;
          tmr_d   = '0;
          state_d = S_IDLE;
        end else if (ACTIVITY) begin
          tmr_d = '0;
        end else if (tmr_q == T_TO) begin
          // Timeout keeps the ID but drops privilege.
          uid_d[11] = 1'b0;
          tmr_d     = '0;
          state_d   = S_IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_LOCK: begin
        uid_d = '0;
        if (tmr_q == T_LK) begin
          lock_d  = 1'b0;
          fail_d  = '0;
          tmr_d   = '0;
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign U_ID     = uid_q;
  assign BUSY     = busy_q;
  assign GRANT    = grant_q;
  assign DENY     = deny_q;
  assign LOCKED   = lock_q;
  assign FAIL_CNT = fail_q;

endmodule

// File: tb/tb_uid_auth_ctrl.sv
// tb_uid_auth_ctrl: scoreboard bench for uid_auth_ctrl.
// Logins queue expected GRANT/DENY records; a monitor pops them on each pulse.
module tb_uid_auth_ctrl;

  logic        CLK;
  logic        RST;
  logic        LOGIN_REQ;
  logic [10:0] LOGIN_ID;
  logic [15:0] LOGIN_PW;
  logic        LOGOUT;
  logic        ACTIVITY;
  logic [11:0] U_ID;
  logic        BUSY;
  logic        GRANT;
  logic        DENY;
  logic        LOCKED;
  logic [1:0]  FAIL_CNT;

  uid_auth_ctrl #(
    .PRIV_PW (16'hA5C3),
    .TIMEOUT (8),
    .MAX_FAIL(3),
    .LOCKOUT (16)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .LOGIN_REQ(LOGIN_REQ),
    .LOGIN_ID (LOGIN_ID),
    .LOGIN_PW (LOGIN_PW),
    .LOGOUT   (LOGOUT),
    .ACTIVITY (ACTIVITY),
    .U_ID     (U_ID),
    .BUSY     (BUSY),
    .GRANT    (GRANT),
    .DENY     (DENY),
    .LOCKED   (LOCKED),
    .FAIL_CNT (FAIL_CNT)
  );

  typedef struct {
    bit          g;
    bit          d;
    logic [11:0] uid;
    logic [1:0]  fc;
    bit          lk;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errs   = 0;
  int   cyc    = 0;

  localparam logic [15:0] PW_OK = 16'hA5C3;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Monitor: every GRANT/DENY pulse must match the head of the queue.
  always @(negedge CLK) begin
    if (GRANT || DENY) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse", {30'd0, GRANT, DENY}, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("grant",    {31'd0, GRANT},    {31'd0, e.g});
        chk("deny",     {31'd0, DENY},     {31'd0, e.d});
        chk("uid",      {20'd0, U_ID},     {20'd0, e.uid});
        chk("fail_cnt", {30'd0, FAIL_CNT}, {30'd0, e.fc});
        chk("locked",   {31'd0, LOCKED},   {31'd0, e.lk});
        chk("latency",  cyc,               e.cyc);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_uid"},  {20'd0, U_ID}, 32'd0);
    chk({nm, "_busy"}, {31'd0, BUSY}, 32'd0);
    chk({nm, "_gd"},   {30'd0, GRANT, DENY}, 32'd0);
    chk({nm, "_lk"},   {31'd0, LOCKED}, 32'd0);
    chk({nm, "_fc"},   {30'd0, FAIL_CNT}, 32'd0);
  endtask

  // Called at a negedge; returns at the negedge after the result edge.
  task automatic login(input logic [10:0] id, input logic [15:0] pw,
                       input bit g, input logic [11:0] uid,
                       input logic [1:0] fc, input bit lk,
                       input bit noise);
    exp_t e;
    e = '{g: g, d: !g, uid: uid, fc: fc, lk: lk, cyc: cyc + 5};
    q.push_back(e);
    LOGIN_REQ = 1'b1;
    LOGIN_ID  = id;
    LOGIN_PW  = pw;
    tick(1);
    LOGIN_REQ = 1'b0;
    chk("busy_start", {31'd0, BUSY}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (noise) begin
        LOGIN_REQ = 1'b1;
        LOGIN_PW  = ~pw;
        LOGOUT    = 1'b1;
      end
      tick(1);
      LOGIN_REQ = 1'b0;
      LOGOUT    = 1'b0;
      LOGIN_PW  = pw;
      chk("busy_window", {31'd0, BUSY}, (i < 3) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    RST = 1'b1;
    LOGIN_REQ = 1'b0;
    LOGIN_ID = '0;
    LOGIN_PW = '0;
    LOGOUT = 1'b0;
    ACTIVITY = 1'b0;
    tick(2);
    chk_zero("reset");
    RST = 1'b0;
    tick(1);

    // Grant with request/logout noise during CHECK.
    login(11'h05A, PW_OK, 1, 12'h85A, 2'd0, 0, 1);
    // Idle timeout; LOGIN_REQ in PRIV is ignored.
    for (int k = 1; k <= 8; k++) begin
      if (k == 3) begin
        LOGIN_REQ = 1'b1;
        LOGIN_PW  = 16'h0000;
      end
      tick(1);
      LOGIN_REQ = 1'b0;
      chk("priv_busy", {31'd0, BUSY}, 32'd0);
      chk("timeout_uid", {20'd0, U_ID},
          (k < 8) ? 32'h85A : 32'h05A);
    end

    // Deny on nibble 0 mismatch.
    login(11'h05A, 16'hA5C2, 0, 12'h05A, 2'd1, 0, 0);

    // Activity at cycle 6 restarts the idle timer.
    login(11'h123, PW_OK, 1, 12'h923, 2'd0, 0, 0);
    for (int k = 1; k <= 14; k++) begin
      if (k == 6) ACTIVITY = 1'b1;
      tick(1);
      ACTIVITY = 1'b0;
      chk("activity_uid", {20'd0, U_ID},
          (k < 14) ? 32'h923 : 32'h123);
    end

    // LOGOUT beats ACTIVITY.
    login(11'h05A, PW_OK, 1, 12'h85A, 2'd0, 0, 0);
    LOGOUT = 1'b1;
    ACTIVITY = 1'b1;
    tick(1);
    LOGOUT = 1'b0;
    ACTIVITY = 1'b0;
    chk("logout_uid", {20'd0, U_ID}, 32'd0);
    tick(1);
    chk("logout_busy", {31'd0, BUSY}, 32'd0);

    // Deny on nibble 3 mismatch, same latency.
    login(11'h05A, 16'h05C3, 0, 12'h05A, 2'd1, 0, 0);
    login(11'h05A, PW_OK, 1, 12'h85A, 2'd0, 0, 0);
    LOGOUT = 1'b1;
    tick(1);
    LOGOUT = 1'b0;
    chk("logout2_uid", {20'd0, U_ID}, 32'd0);

    // Three failures -> lockout.
    login(11'h05A, 16'h0000, 0, 12'h05A, 2'd1, 0, 0);
    login(11'h05A, 16'h0000, 0, 12'h05A, 2'd2, 0, 0);
    login(11'h05A, 16'h0000, 0, 12'h000, 2'd3, 1, 0);
    for (int k = 1; k <= 16; k++) begin
      if (k == 4 || k == 16) begin
        LOGIN_REQ = 1'b1;
        LOGIN_ID  = 11'h05A;
        LOGIN_PW  = PW_OK;
        LOGOUT    = (k == 4);
        ACTIVITY  = (k == 4);
      end
      tick(1);
      LOGIN_REQ = 1'b0;
      LOGOUT    = 1'b0;
      ACTIVITY  = 1'b0;
      chk("lock_busy", {31'd0, BUSY}, 32'd0);
      chk("lock_uid", {20'd0, U_ID}, 32'd0);
      chk("lock_flag", {31'd0, LOCKED}, (k < 16) ? 32'd1 : 32'd0);
    end
    chk("lock_fc_clear", {30'd0, FAIL_CNT}, 32'd0);
    tick(1);
    chk("lock_exit_busy", {31'd0, BUSY}, 32'd0);
    login(11'h05A, PW_OK, 1, 12'h85A, 2'd0, 0, 0);

    // Reset while privileged.
    RST = 1'b1;
    tick(1);
    RST = 1'b0;
    chk_zero("rst_priv");

    // Reset mid-CHECK with a pending failure count.
    login(11'h05A, 16'hA5C2, 0, 12'h05A, 2'd1, 0, 0);
    LOGIN_REQ = 1'b1;
    LOGIN_ID  = 11'h05A;
    LOGIN_PW  = PW_OK;
    tick(1);
    LOGIN_REQ = 1'b0;
    tick(1);
    RST = 1'b1;
    tick(1);
    RST = 1'b0;
    chk_zero("rst_check");
    tick(4);
    chk("rst_check_idle", {31'd0, BUSY}, 32'd0);
    login(11'h05A, PW_OK, 1, 12'h85A, 2'd0, 0, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++) tick(1);
    chk("queue_drained", q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
